// File: rtl/piano_pkg.sv
// Shared piano definitions: note half-period table (100 MHz clock cycles),
// counter and note widths, seven-segment letter codes and the decoder states.
// The piano tone generator uses the same table, so both sides agree on pitch.
package piano_pkg;

  localparam int NOTE_W    = 8;
  localparam int CNT_W     = 18;
  localparam int NUM_NOTES = 8;

  // Active-low segment codes, bit7 = dp, bits6..0 = g..a
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_G     = 8'hC2;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED
  } state_t;

  // Half-period of each note, index 0 = C4 up to index 7 = C5
  function automatic logic [CNT_W-1:0] half_period(input logic [2:0] idx);
    logic [CNT_W-1:0] h;
    h = 18'd191113;
    case (idx)
      3'd0: h = 18'd191113;
      3'd1: h = 18'd170265;
      3'd2: h = 18'd151685;
      3'd3: h = 18'd143172;
      3'd4: h = 18'd127551;
      3'd5: h = 18'd113636;
      3'd6: h = 18'd101239;
      3'd7: h = 18'd95557;
      default: h = 18'd191113;
    endcase
    return h;
  endfunction

  // Table index to one-hot note bus: index 0 (C4) lands on bit 7
  function automatic logic [NOTE_W-1:0] note_onehot(input logic [2:0] idx);
    return NOTE_W'(8'h80) >> idx;
  endfunction

endpackage

// File: rtl/note_seg.sv
// One-hot note to seven-segment letter encoder. It only exists when
// SEG_DISPLAY_EN is defined; the plain build carries no display logic.
// C4 and C5 share the letter "C"; anything not exactly one-hot is blank.
`ifdef SEG_DISPLAY_EN
module note_seg
  import piano_pkg::*;
(
  input  logic [NOTE_W-1:0] note,
  output logic [7:0]        seg
);

  // Pick the letter for the single active note bit
  always_comb begin
    seg = SEG_BLANK;
    case (note)
      8'h80:   seg = SEG_C;
      8'h40:   seg = SEG_D;
      8'h20:   seg = SEG_E;
      8'h10:   seg = SEG_F;
      8'h08:   seg = SEG_G;
      8'h04:   seg = SEG_A;
      8'h02:   seg = SEG_B;
      8'h01:   seg = SEG_C;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`endif

// File: rtl/note_decoder.sv
// Piano note decoder: measures the half-period of the incoming square wave,
// matches it against the piano_pkg table and locks after LOCK_N consecutive
// agreeing half-periods. Optional letter display under SEG_DISPLAY_EN;
// without it seg/an are tied off to blank.
module note_decoder
  import piano_pkg::*;
#(
  parameter int TOL    = 512,
  parameter int LOCK_N = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FREQ,
  output logic [NOTE_W-1:0] note,
  output logic              note_valid,
  output logic [7:0]        Led,
  output logic [7:0]        seg,
  output logic [3:0]        an
);

  localparam logic [CNT_W-1:0] TOL_CNT  = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(191113 + TOL + 1);
  localparam logic [3:0]       LOCK_CNT = 4'(LOCK_N);

  logic              sync1, sync2, sync3, edge_pulse;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  period;
  logic              sat;
  logic              match;
  logic [2:0]        match_idx;
  state_t            state, state_n;
  logic [2:0]        cand, cand_n;
  logic [3:0]        mcnt, mcnt_n;
  logic [NOTE_W-1:0] note_n;
  logic              valid_n;

  function automatic logic near(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W-1:0] d;
    d = (a >= b) ? a - b : b - a;
    return d <= TOL_CNT;
  endfunction

  // Two-flop synchroniser plus a registered toggle detector on either edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync1      <= FREQ;
      sync2      <= sync1;
      sync3      <= sync2;
      edge_pulse <= sync2 ^ sync3;
    end
  end

  // Half-period counter, restarted by every edge and parked at HALF_MAX
  always_ff @(posedge CLK) begin
    if (RESET || edge_pulse) cnt <= '0;
    else if (!sat)           cnt <= cnt + CNT_W'(1);
  end

  assign sat = (cnt == HALF_MAX);
  // The clear cycle reads as zero, so the count at the closing edge is one
  // short of the true half-period
  assign period = cnt + CNT_W'(1);

  // Lowest table index within tolerance wins
  always_comb begin
    match     = 1'b0;
    match_idx = 3'd0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (near(period, half_period(3'(i)))) begin
        match     = 1'b1;
        match_idx = 3'(i);
      end
    end
  end

  // FSM and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      cand       <= 3'd0;
      mcnt       <= 4'd0;
      note       <= '0;
      note_valid <= 1'b0;
    end else begin
      state      <= state_n;
      cand       <= cand_n;
      mcnt       <= mcnt_n;
      note       <= note_n;
      note_valid <= valid_n;
    end
  end

  // Next-state: classify on edges, fall back to IDLE on silence
  always_comb begin
    state_n = state;
    cand_n  = cand;
    mcnt_n  = mcnt;
    note_n  = note;
    valid_n = note_valid;
    if (edge_pulse) begin
      case (state)
        IDLE: begin
          state_n = MEASURE;
          mcnt_n  = 4'd0;
        end
        MEASURE: begin
          if (!match) begin
            mcnt_n = 4'd0;
          end else begin
            if (match_idx == cand) begin
              mcnt_n = mcnt + 4'd1;
            end else begin
              cand_n = match_idx;
              mcnt_n = 4'd1;
            end
            if (mcnt_n >= LOCK_CNT) begin
              state_n = LOCKED;
              note_n  = note_onehot(cand_n);
              valid_n = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (!(match && match_idx == cand)) begin
            state_n = MEASURE;
            note_n  = '0;
            valid_n = 1'b0;
            if (match) begin
              cand_n = match_idx;
              mcnt_n = 4'd1;
            end else begin
              mcnt_n = 4'd0;
            end
          end
        end
        default: begin
          state_n = IDLE;
          mcnt_n  = 4'd0;
          note_n  = '0;
          valid_n = 1'b0;
        end
      endcase
    end else if (sat) begin
      state_n = IDLE;
      mcnt_n  = 4'd0;
      note_n  = '0;
      valid_n = 1'b0;
    end
  end

  assign Led = note;

`ifdef SEG_DISPLAY_EN
  logic [7:0] seg_code;

  note_seg u_note_seg (
    .note (note_n),
    .seg  (seg_code)
  );

  // Display registers track the next note so they change with note itself
  always_ff @(posedge CLK) begin
    if (RESET) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
    end else begin
      seg <= valid_n ? seg_code : SEG_BLANK;
      an  <= valid_n ? 4'b1110 : 4'hF;
    end
  end
`else
  assign seg = SEG_BLANK;
  assign an  = 4'hF;
`endif

endmodule

// File: tb/tb_note_decoder.sv
// Self-checking bench for note_decoder. Expected outputs are queued with the
// cycle they must appear in and compared on the falling clock edge.
module tb_note_decoder;

  logic       CLK   = 1'b0;
  logic       RESET = 1'b1;
  logic       FREQ  = 1'b0;
  logic [7:0] note;
  logic       note_valid;
  logic [7:0] Led;
  logic [7:0] seg;
  logic [3:0] an;

  int cyc       = 0;
  int total     = 0;
  int passed    = 0;
  int last_edge = 0;

  typedef struct {
    int         at;
    string      tag;
    logic [7:0] note;
    logic       valid;
    logic [7:0] seg;
    logic [3:0] an;
  } exp_t;

  exp_t sb[$];

  note_decoder #(.TOL(512), .LOCK_N(2)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .FREQ       (FREQ),
    .note       (note),
    .note_valid (note_valid),
    .Led        (Led),
    .seg        (seg),
    .an         (an)
  );

  // 100 MHz clock
  always #5 CLK = ~CLK;

  // Cycle number: after the k-th rising edge cyc reads k
  always @(posedge CLK) cyc <= cyc + 1;

  // Expected display letter for a note, or blank when the display is absent
  function automatic logic [7:0] expSeg(input logic [7:0] n);
    logic [7:0] s;
    s = 8'hFF;
`ifdef SEG_DISPLAY_EN
    case (n)
      8'h80, 8'h01: s = 8'hC6;
      8'h40:        s = 8'hA1;
      8'h20:        s = 8'h86;
      8'h10:        s = 8'h8E;
      8'h08:        s = 8'hC2;
      8'h04:        s = 8'h88;
      8'h02:        s = 8'h83;
      default:      s = 8'hFF;
    endcase
`endif
    return s;
  endfunction

  function automatic logic [3:0] expAn(input logic [7:0] n);
`ifdef SEG_DISPLAY_EN
    return (n != 8'h00) ? 4'b1110 : 4'hF;
`else
    return (n != 8'h00) ? 4'hF : 4'hF;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want)
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, want);
    else
      passed++;
  endtask

  // Queue an expectation in cycle order
  task automatic expectAt(input int at, input string tag, input logic [7:0] n);
    exp_t e;
    int   i;
    e.at    = at;
    e.tag   = tag;
    e.note  = n;
    e.valid = (n != 8'h00);
    e.seg   = expSeg(n);
    e.an    = expAn(n);
    i = sb.size();
    while (i > 0 && sb[i-1].at > at) i--;
    sb.insert(i, e);
  endtask

  task automatic toggle(input int n);
    repeat (n) @(negedge CLK);
    FREQ      = ~FREQ;
    last_edge = cyc;
  endtask

  // Three edges at the given half-period spacing; the first only arms the FSM
  task automatic applyStimulus(input int half, input logic [7:0] want, input string tag);
    toggle(4);
    expectAt(last_edge + 4, {tag, "_e1"}, 8'h00);
    toggle(half);
    expectAt(last_edge + 4, {tag, "_e2"}, 8'h00);
    toggle(half);
    expectAt(last_edge + 3, {tag, "_e3pre"}, 8'h00);
    expectAt(last_edge + 4, {tag, "_e3"}, want);
    expectAt(last_edge + 20, {tag, "_hold"}, want);
  endtask

  task automatic resetDut();
    repeat (30) @(negedge CLK);
    FREQ  = 1'b0;
    RESET = 1'b1;
    expectAt(cyc + 1, "rst", 8'h00);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    expectAt(cyc + 3, "rst_after", 8'h00);
  endtask

  // Scoreboard: compare every queued expectation in its cycle
  initial begin : scoreboard
    exp_t e;
    forever begin
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checkOutput({e.tag, "/note"},  32'(note),       32'(e.note));
        checkOutput({e.tag, "/valid"}, 32'(note_valid), 32'(e.valid));
        checkOutput({e.tag, "/Led"},   32'(Led),        32'(e.note));
        checkOutput({e.tag, "/seg"},   32'(seg),        32'(e.seg));
        checkOutput({e.tag, "/an"},    32'(an),         32'(e.an));
      end
    end
  end

  // Main stimulus sequence
  initial begin : stimulus
    int m;
    expectAt(1, "in_reset1", 8'h00);
    expectAt(2, "in_reset2", 8'h00);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    expectAt(cyc + 3, "post_reset", 8'h00);

    // A4 lock
    applyStimulus(113636, 8'h04, "A4");

    // Tolerance boundary around C5
    resetDut();
    applyStimulus(95557 + 512, 8'h01, "C5_tol_in");
    resetDut();
    applyStimulus(95557 + 513, 8'h00, "C5_tol_out");

    // E4 lock, then switch to F4
    resetDut();
    applyStimulus(151685, 8'h20, "E4");
    toggle(143172);
    expectAt(last_edge + 3, "F4_f1pre", 8'h20);
    expectAt(last_edge + 4, "F4_f1", 8'h00);
    toggle(143172);
    expectAt(last_edge + 3, "F4_f2pre", 8'h00);
    expectAt(last_edge + 4, "F4_f2", 8'h10);

    // G4 lock, then silence until the counter saturates
    resetDut();
    applyStimulus(127551, 8'h08, "G4");
    expectAt(last_edge + 191620, "silence_pre", 8'h08);
    expectAt(last_edge + 191640, "silence", 8'h00);
    repeat (191650) @(negedge CLK);

    // D4 lock, reset while locked with FREQ high, relock
    resetDut();
    applyStimulus(170265, 8'h40, "D4");
    repeat (30) @(negedge CLK);
    RESET = 1'b1;
    expectAt(cyc + 1, "D4_midreset", 8'h00);
    @(negedge CLK);
    RESET = 1'b0;
    m = cyc;
    expectAt(m + 4, "D4_r1", 8'h00);
    toggle(170265);
    expectAt(last_edge + 4, "D4_r2", 8'h00);
    toggle(170265);
    expectAt(last_edge + 3, "D4_r3pre", 8'h00);
    expectAt(last_edge + 4, "D4_r3", 8'h40);

    // C4 lock
    resetDut();
    applyStimulus(191113, 8'h80, "C4");

    repeat (40) @(negedge CLK);
    checkOutput("drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
